// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types and byte-merge helper for the memory port arbiter
package memory_arbiter_pkg;
  typedef enum logic {ISSUE, RMW_WRITE} state_t;
  typedef enum logic [1:0] {OWNER_NONE, OWNER_FETCH, OWNER_DATA} owner_t;
  typedef enum logic {REQ_FETCH, REQ_DATA} req_t;
  localparam logic [3:0] FULL_WORD_MASK = 4'hF;
  function automatic logic [31:0] merge_bytes(input logic [3:0] mask, input logic [31:0] wr_word, input logic [31:0] old_word);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i+:8] = mask[i] ? wr_word[8*i+:8] : old_word[8*i+:8];
    return w;
  endfunction
endpackage

// File: rtl/memory_rr_arbiter_2.sv
// memory_rr_arbiter_2: two-requester round-robin arbiter with last_grant register
module memory_rr_arbiter_2
  import memory_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic req_fetch,
  input  logic req_data,
  input  logic advance,
  output logic grant_fetch,
  output logic grant_data
);
  req_t last_grant;
  always_comb begin
    grant_fetch = enable && req_fetch && (!req_data || last_grant == REQ_DATA);
    grant_data  = enable && req_data && (!req_fetch || last_grant == REQ_FETCH);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= REQ_DATA;
    else if (advance) last_grant <= grant_data ? REQ_DATA : REQ_FETCH;
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin share of memory port A between fetch and load/store, with RMW for partial stores
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_request_valid,
  output logic        fetch_request_ready,
  input  logic [31:0] fetch_address,
  output logic        fetch_response_valid,
  output logic [31:0] fetch_response_data,
  input  logic        data_request_valid,
  output logic        data_request_ready,
  input  logic        data_write_enable,
  input  logic [3:0]  data_byte_enable,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write_data,
  output logic        data_response_valid,
  output logic [31:0] data_response_data,
  output logic        memory_write_enable,
  output logic [31:0] memory_access_address,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_read_data
);
  state_t state;
  owner_t owner;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [31:0] hold_data;
  logic [3:0] hold_mask;
  logic grant_fetch, grant_data, full_store, partial_store;
  logic [ADDR_WIDTH-1:0] addr;
  logic unused_addr_bits;
  memory_rr_arbiter_2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (rst_n && state == ISSUE),
    .req_fetch   (fetch_request_valid),
    .req_data    (data_request_valid),
    .advance     (grant_fetch || grant_data),
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data)
  );
  always_comb begin
    full_store            = grant_data && data_write_enable && data_byte_enable == FULL_WORD_MASK;
    partial_store         = grant_data && data_write_enable && data_byte_enable != 4'h0 && !full_store;
    fetch_request_ready   = grant_fetch;
    data_request_ready    = grant_data;
    addr                  = state == RMW_WRITE ? hold_addr :
                            grant_fetch ? fetch_address[ADDR_WIDTH-1:0] :
                            grant_data ? data_address[ADDR_WIDTH-1:0] : '0;
    memory_access_address = 32'(addr);
    memory_write_enable   = state == RMW_WRITE || full_store;
    memory_write_data     = state == RMW_WRITE ? merge_bytes(hold_mask, hold_data, memory_read_data) :
                            full_store ? data_write_data : '0;
    fetch_response_valid  = owner == OWNER_FETCH;
    data_response_valid   = owner == OWNER_DATA;
    fetch_response_data   = rst_n ? memory_read_data : '0;
    data_response_data    = rst_n ? memory_read_data : '0;
    unused_addr_bits      = ^{fetch_address[31:ADDR_WIDTH], data_address[31:ADDR_WIDTH]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ISSUE;
      owner     <= OWNER_NONE;
      hold_addr <= '0;
      hold_data <= '0;
      hold_mask <= '0;
    end else begin
      state <= partial_store ? RMW_WRITE : ISSUE;
      owner <= (state == RMW_WRITE || (grant_data && !partial_store)) ? OWNER_DATA :
               grant_fetch ? OWNER_FETCH : OWNER_NONE;
      if (partial_store) begin
        hold_addr <= data_address[ADDR_WIDTH-1:0];
        hold_data <= data_write_data;
        hold_mask <= data_byte_enable;
      end
    end
endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares one port of the dual-port word memory between the core's instruction-fetch requester and its load/store requester.
- Uses round-robin arbitration with a valid/ready request handshake and fixed-latency response pulses.
- Converts partial-word stores into a read-modify-write, because the memory only writes whole 32-bit words.
- Sits between the core front-end/LSU and memory port A; it runs on the same clock as that port.

Parameters:
- ADDR_WIDTH, 12, number of word-address bits forwarded to memory; the memory holds 4096 words.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_request_valid  in  1  fetch request pending.
- fetch_request_ready  out  1  fetch request accepted this cycle.
- fetch_address  in  32  fetch word address.
- fetch_response_valid  out  1  one-cycle pulse; fetch_response_data is valid.
- fetch_response_data  out  32  instruction word.
- data_request_valid  in  1  load/store request pending.
- data_request_ready  out  1  load/store request accepted this cycle.
- data_write_enable  in  1  1 = store, 0 = load.
- data_byte_enable  in  4  store byte lanes; bit i selects bits [8i+7:8i].
- data_address  in  32  data word address.
- data_write_data  in  32  store data, already lane-aligned.
- data_response_valid  out  1  one-cycle pulse; completes a load or store.
- data_response_data  out  32  loaded word, or for a store the word now held in memory.
- memory_write_enable  out  1  to memory port write enable.
- memory_access_address  out  32  to memory port address.
- memory_write_data  out  32  to memory port write data.
- memory_read_data  in  32  from memory port; valid one cycle after the address is sampled; write-first on a write.

Behaviour:
- Memory timing. The memory samples address, write enable and write data at edge E. memory_read_data is valid in the cycle after E. On a write it returns the written word.
- Address mapping. memory_access_address = {zeros, addr[ADDR_WIDTH-1:0]}. Upper bits are discarded, so 0x1000 maps to 0 and 0xFFF is the last word.
- State machine has two states:
  - ISSUE: normal arbitration.
  - RMW_WRITE: the write half of a partial store.
- Arbitration happens in ISSUE only. It is combinational from the two valids and last_grant:
  - If only one requester is valid, it is granted.
  - If both are valid, grant the requester not equal to last_grant.
  - Only the granted requester sees ready = 1; in RMW_WRITE both readies are 0.
  - last_grant updates on every handshake.
- In ISSUE, the memory outputs are driven combinationally from the granted request:
  - Fetch: write_enable = 0.
  - Load: write_enable = 0.
  - Full store (byte_enable == 4'hF): write_enable = 1, write_data = data_write_data.
  - Partial store (byte_enable in 4'h1..4'hE): write_enable = 0, which is the read half. Register the address, data and mask, then go to RMW_WRITE.
  - byte_enable == 4'h0 store: treated as a load, with no write.
  - No grant: write_enable = 0, address = 0, write_data = 0.
- In RMW_WRITE:
  - Drive write_enable = 1 and the held address.
  - write_data = per-lane mask ? held data : memory_read_data.
  - Return to ISSUE next cycle. No grant is made in this cycle.
- Responses.
  - A registered response owner (NONE/FETCH/DATA) is set on each handshake, or on RMW_WRITE for a partial store.
  - In the cycle after the memory sampled the owner's final access, the owner's response_valid = 1 and response_data = memory_read_data (pass-through).
  - The other response_valid = 0. Response data is don't-care when valid = 0, but is driven as memory_read_data.
- Latency from handshake edge H:
  - Fetch, load and full store: response during the cycle after H.
  - Partial store: response two cycles after H.
- Throughput. A new handshake may occur in the same cycle a response is presented, giving one access per cycle. A partial store occupies 2 cycles.
- There is no response back-pressure; requesters must accept each pulse.
- Requesters hold valid and payload stable until ready.
- Reset values (asynchronous, rst_n = 0):
  - State = ISSUE, owner = NONE, last_grant = DATA (so fetch wins the first conflict).
  - All held registers = 0.
  - All outputs 0.
  - Reset mid-RMW aborts the write, and the pending response is dropped.

Decomposition:
- Shared package memory_arbiter_pkg holds:
  - state enum {ISSUE, RMW_WRITE};
  - owner enum {OWNER_NONE, OWNER_FETCH, OWNER_DATA};
  - requester enum {REQ_FETCH, REQ_DATA};
  - constant FULL_WORD_MASK = 4'hF;
  - byte-merge function.
- One sub-module, memory_rr_arbiter_2: a two-requester round-robin with the last_grant register, grant outputs and an advance input.

Test Plan:
- Reset, then fetch only at 0x004, word 0x00000013: ready = 1 at once; fetch_response_valid the next cycle with 0x00000013; data response stays 0.
- Both valid every cycle after reset, fetch 0x000 and load 0x010: grants alternate F, D, F, D; responses alternate each cycle with the matching words; no bubbles.
- Full store 0x12345678 to 0x020, then load 0x020:
  - Store response = 0x12345678 (write-first).
  - Load returns 0x12345678.
- Partial store to word 0x010 holding 0xAABBCCDD, byte_enable 4'b0010, data 0x0000EE00:
  - Cycle H+1: write_enable = 1, write_data = 0xAABBEEDD.
  - Both readies are 0 in H+1.
  - data_response_data = 0xAABBEEDD at H+2.
- Address 0x00001010 load: memory_access_address = 0x010.
- byte_enable 4'h0 store: no write occurs; response returns the old word.
- rst_n low during RMW_WRITE: no write reaches memory; no response appears; outputs are 0 immediately; fetch wins the first conflict after release.
